// File: rtl/dp_seq_datapath_pkg.sv
// Shared definitions for the sequenced datapath: ALU op codes, FSM state encoding, defaults.
package dp_seq_datapath_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSB = 3'b101,
        OP_SLT   = 3'b110,
        OP_SLL   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_READ = 2'b01,
        ST_EXEC = 2'b10,
        ST_WB   = 2'b11
    } state_e;

    localparam bit ZERO_R0_DEF = 1'b1;

endpackage

// File: rtl/dp_seq_datapath_alu.sv
// Combinational 8-op ALU; carry/overflow only meaningful for ADD/SUB, zero derived by the caller.
module dp_alu
    import dp_seq_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow
);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        // carry out of A + ~B + 1 is the unsigned no-borrow indication
        diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        y        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        unique case (op)
            OP_ADD: begin
                y        = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y        = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_PASSB: y = b;
            OP_SLT:   y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:   y = a << b[SHW-1:0];
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/dp_seq_datapath.sv
// Sequenced datapath: register file, command/operand regs and IDLE->READ->EXEC->WB command FSM.
module dp_seq_datapath
    import dp_seq_datapath_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter bit ZERO_R0 = ZERO_R0_DEF
) (
    input  logic              dp_clk,
    input  logic              dp_reset,
    input  logic              dp_ld_en,
    input  logic [ADDR_W-1:0] dp_ld_addr,
    input  logic [WIDTH-1:0]  dp_ld_data,
    input  logic              dp_start,
    output logic              dp_ready,
    input  logic [2:0]        dp_op,
    input  logic [ADDR_W-1:0] dp_rs1,
    input  logic [ADDR_W-1:0] dp_rs2,
    input  logic [ADDR_W-1:0] dp_rd,
    input  logic              dp_use_imm,
    input  logic [WIDTH-1:0]  dp_imm,
    output logic              dp_done,
    output logic [WIDTH-1:0]  dp_result,
    output logic              dp_carry,
    output logic              dp_overflow,
    output logic              dp_zero,
    input  logic [ADDR_W-1:0] dp_rd_addr,
    output logic [WIDTH-1:0]  dp_rd_data
);
    localparam int NREG = 2**ADDR_W;

    state_e                       state, state_nxt;
    logic [NREG-1:0][WIDTH-1:0]   rf;
    alu_op_e                      cmd_op;
    logic [ADDR_W-1:0]            cmd_rs1, cmd_rs2, cmd_rd;
    logic                         cmd_use_imm;
    logic [WIDTH-1:0]             cmd_imm;
    logic [WIDTH-1:0]             opa, opb;
    logic [WIDTH-1:0]             alu_y;
    logic                         alu_c, alu_v;

    function automatic logic [WIDTH-1:0] rf_rd(input logic [ADDR_W-1:0] addr);
        return (ZERO_R0 && addr == '0) ? '0 : rf[addr];
    endfunction

    function automatic logic wr_ok(input logic [ADDR_W-1:0] addr);
        return !(ZERO_R0 && addr == '0);
    endfunction

    always_ff @(posedge dp_clk or negedge dp_reset)
        if (!dp_reset) state <= ST_IDLE;
        else           state <= state_nxt;

    always_comb begin
        state_nxt = state;
        dp_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                dp_ready = 1'b1;
                if (dp_start) state_nxt = ST_READ;
            end
            ST_READ: state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_WB;
            ST_WB:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .op       (cmd_op),
        .a        (opa),
        .b        (opb),
        .y        (alu_y),
        .carry    (alu_c),
        .overflow (alu_v)
    );

    always_ff @(posedge dp_clk or negedge dp_reset) begin
        if (!dp_reset) begin
            cmd_op      <= OP_ADD;
            cmd_rs1     <= '0;
            cmd_rs2     <= '0;
            cmd_rd      <= '0;
            cmd_use_imm <= 1'b0;
            cmd_imm     <= '0;
            opa         <= '0;
            opb         <= '0;
            dp_result   <= '0;
            dp_carry    <= 1'b0;
            dp_overflow <= 1'b0;
            dp_zero     <= 1'b0;
            dp_done     <= 1'b0;
            dp_rd_data  <= '0;
        end else begin
            dp_done    <= (state == ST_WB);
            dp_rd_data <= rf_rd(dp_rd_addr);
            if (state == ST_IDLE && dp_start) begin
                cmd_op      <= alu_op_e'(dp_op);
                cmd_rs1     <= dp_rs1;
                cmd_rs2     <= dp_rs2;
                cmd_rd      <= dp_rd;
                cmd_use_imm <= dp_use_imm;
                cmd_imm     <= dp_imm;
            end
            if (state == ST_READ) begin
                opa <= rf_rd(cmd_rs1);
                opb <= cmd_use_imm ? cmd_imm : rf_rd(cmd_rs2);
            end
            if (state == ST_EXEC) begin
                dp_result   <= alu_y;
                dp_carry    <= alu_c;
                dp_overflow <= alu_v;
                dp_zero     <= (alu_y == '0);
            end
        end
    end

    // External loads and writeback never collide: loads need IDLE, writeback happens in WB.
    always_ff @(posedge dp_clk or negedge dp_reset) begin
        if (!dp_reset) begin
            rf <= '0;
        end else begin
            if (dp_ld_en && state == ST_IDLE && wr_ok(dp_ld_addr))
                rf[dp_ld_addr] <= dp_ld_data;
            if (state == ST_WB && wr_ok(cmd_rd))
                rf[cmd_rd] <= dp_result;
        end
    end

endmodule
